// File: rtl/operand_serializer_if.sv
// operand_serializer_if: parallel-in handshake and serial-out frame bus for operand_serializer
interface operand_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic hold;
  logic dout;
  logic dout_valid;
  logic dout_last;
  logic busy;
  modport master(output din, din_valid, hold, input din_ready, dout, dout_valid, dout_last, busy);
  modport slave(input din, din_valid, hold, output din_ready, dout, dout_valid, dout_last, busy);
endinterface

// File: rtl/operand_serializer.sv
// operand_serializer: frames a parallel word as start bit, LSB-first data and optional even parity on a 1-bit stream
module operand_serializer #(
  parameter int WIDTH = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  operand_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] PARITY = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic par;
  logic dout_r;
  logic valid_r;
  logic last_r;
  logic xfer;
  assign bus.din_ready = !rst && !bus.hold && (state == IDLE || last_r);
  assign xfer = bus.din_valid && bus.din_ready;
  // hold masks the registered bit in the same cycle so the stalled bit reappears intact on release
  assign bus.dout = dout_r && !bus.hold;
  assign bus.dout_valid = valid_r && !bus.hold;
  assign bus.dout_last = last_r && !bus.hold;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      dout_r <= 1'b0;
      valid_r <= 1'b0;
      last_r <= 1'b0;
    end else if (!bus.hold) begin
      if (xfer) begin
        state <= START;
        sh <= bus.din;
        par <= 1'b0;
        cnt <= '0;
        dout_r <= 1'b1;
        valid_r <= 1'b1;
        last_r <= 1'b0;
      end else if (state == START) begin
        state <= DATA;
        cnt <= '0;
        dout_r <= sh[0];
        sh <= sh >> 1;
        par <= sh[0];
        last_r <= 1'b0;
      end else if (state == DATA && cnt != CW'(WIDTH - 1)) begin
        cnt <= cnt + 1'b1;
        dout_r <= sh[0];
        sh <= sh >> 1;
        par <= par ^ sh[0];
        last_r <= !PARITY_EN && cnt == CW'(WIDTH - 2);
      end else if (state == DATA && PARITY_EN) begin
        state <= PARITY;
        dout_r <= par;
        last_r <= 1'b1;
      end else begin
        state <= IDLE;
        dout_r <= 1'b0;
        valid_r <= 1'b0;
        last_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: scoreboard bench for an 8-bit parity serializer and a 4-bit no-parity serializer
module tb_operand_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic [1:0] exp1;
  logic [1:0] exp2;
  operand_serializer_if #(.WIDTH(8)) if1();
  operand_serializer_if #(.WIDTH(4)) if2();
  operand_serializer #(.WIDTH(8), .PARITY_EN(1'b1)) dut1(.clk(clk), .rst(rst), .bus(if1));
  operand_serializer #(.WIDTH(4), .PARITY_EN(1'b0)) dut2(.clk(clk), .rst(rst), .bus(if2));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (if1.dout_valid === 1'b1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL mon1_extra: got dout=%b last=%b, expected no bit", if1.dout, if1.dout_last);
      end else begin
        exp1 = q1.pop_front();
        if ({if1.dout, if1.dout_last} !== exp1) begin
          errors++;
          $display("FAIL mon1_bit: got dout/last=%b, expected %b", {if1.dout, if1.dout_last}, exp1);
        end
      end
    end else if ({if1.dout_valid, if1.dout, if1.dout_last} !== 3'b000) begin
      errors++;
      $display("FAIL mon1_idle: got valid/dout/last=%b, expected 000", {if1.dout_valid, if1.dout, if1.dout_last});
    end
  end
  always @(negedge clk) begin
    checks++;
    if (if2.dout_valid === 1'b1) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL mon2_extra: got dout=%b last=%b, expected no bit", if2.dout, if2.dout_last);
      end else begin
        exp2 = q2.pop_front();
        if ({if2.dout, if2.dout_last} !== exp2) begin
          errors++;
          $display("FAIL mon2_bit: got dout/last=%b, expected %b", {if2.dout, if2.dout_last}, exp2);
        end
      end
    end else if ({if2.dout_valid, if2.dout, if2.dout_last} !== 3'b000) begin
      errors++;
      $display("FAIL mon2_idle: got valid/dout/last=%b, expected 000", {if2.dout_valid, if2.dout, if2.dout_last});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [7:0] d, input int n);
    logic [1:0] f[10];
    f[0] = 2'b10;
    for (int i = 0; i < 8; i++) f[i+1] = {d[i], 1'b0};
    f[9] = {^d, 1'b1};
    for (int i = 0; i < n; i++) q1.push_back(f[i]);
  endtask
  task automatic push2(input logic [3:0] d);
    q2.push_back(2'b10);
    for (int i = 0; i < 4; i++) q2.push_back({d[i], i == 3});
  endtask
  task automatic test_reset();
    rst = 1'b1;
    if1.hold = 1'b0; if1.din_valid = 1'b1; if1.din = 8'h3C;
    if2.hold = 1'b0; if2.din_valid = 1'b1; if2.din = 4'h9;
    for (int c = 0; c < 3; c++) begin
      tick(); #3;
      checks++;
      if ({if1.din_ready, if1.dout_valid, if1.busy} !== 3'b000) begin
        errors++; $display("FAIL reset_dut1 c=%0d: got ready/valid/busy=%b, expected 000", c, {if1.din_ready, if1.dout_valid, if1.busy});
      end
      checks++;
      if ({if2.din_ready, if2.dout_valid, if2.busy} !== 3'b000) begin
        errors++; $display("FAIL reset_dut2 c=%0d: got ready/valid/busy=%b, expected 000", c, {if2.din_ready, if2.dout_valid, if2.busy});
      end
    end
    tick(); rst = 1'b0; if1.din_valid = 1'b0; if2.din_valid = 1'b0; #3;
    checks++;
    if ({if1.din_ready, if2.din_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b, expected 11", {if1.din_ready, if2.din_ready});
    end
    for (int c = 0; c < 3; c++) begin
      tick(); #3;
      checks++;
      if ({if1.dout_valid, if2.dout_valid, if1.busy, if2.busy} !== 4'b0000) begin
        errors++; $display("FAIL reset_no_frame c=%0d: got valid1/valid2/busy1/busy2=%b, expected 0000", c, {if1.dout_valid, if2.dout_valid, if1.busy, if2.busy});
      end
    end
  endtask
  task automatic test_basic();
    logic [0:9] seq = 10'b1101001010;
    tick(); if1.din = 8'hA5; if1.din_valid = 1'b1; #3;
    checks++;
    if (if1.din_ready !== 1'b1) begin errors++; $display("FAIL basic_ready0: got %b, expected 1", if1.din_ready); end
    push1(8'hA5, 10);
    for (int c = 1; c <= 10; c++) begin
      tick(); if1.din_valid = 1'b0; if1.din = 8'($urandom); #3;
      checks++;
      if ({if1.dout_valid, if1.busy, if1.din_ready, if1.dout_last, if1.dout} !== {2'b11, c == 10, c == 10, seq[c-1]}) begin
        errors++; $display("FAIL basic c=%0d: got valid/busy/ready/last/dout=%b, expected %b", c, {if1.dout_valid, if1.busy, if1.din_ready, if1.dout_last, if1.dout}, {2'b11, c == 10, c == 10, seq[c-1]});
      end
    end
    tick(); #3;
    checks++;
    if ({if1.dout_valid, if1.busy, q1.size() == 0} !== 3'b001) begin
      errors++; $display("FAIL basic_end: got valid/busy/qempty=%b, expected 001", {if1.dout_valid, if1.busy, q1.size() == 0});
    end
  endtask
  task automatic test_back_to_back();
    logic [0:9] seq = 10'b1100000001;
    tick(); if1.din = 8'hA5; if1.din_valid = 1'b1; #3;
    push1(8'hA5, 10);
    for (int c = 1; c <= 20; c++) begin
      tick(); if1.din = 8'h01; if1.din_valid = c <= 10; #3;
      checks++;
      if ({if1.dout_valid, if1.din_ready} !== {1'b1, c == 10 || c == 20}) begin
        errors++; $display("FAIL b2b c=%0d: got valid/ready=%b, expected %b", c, {if1.dout_valid, if1.din_ready}, {1'b1, c == 10 || c == 20});
      end
      if (c > 10) begin
        checks++;
        if (if1.dout !== seq[c-11]) begin errors++; $display("FAIL b2b_bit c=%0d: got %b, expected %b", c, if1.dout, seq[c-11]); end
      end
      if (c == 10) push1(8'h01, 10);
    end
    tick(); #3;
    checks++;
    if ({if1.busy, q1.size() == 0} !== 2'b01) begin
      errors++; $display("FAIL b2b_end: got busy/qempty=%b, expected 01", {if1.busy, q1.size() == 0});
    end
  endtask
  task automatic test_hold();
    logic h;
    tick(); if1.din = 8'hA5; if1.din_valid = 1'b1; #3;
    push1(8'hA5, 10);
    for (int c = 1; c <= 13; c++) begin
      h = c >= 4 && c <= 6;
      tick(); if1.din_valid = 1'b0; if1.hold = h; #3;
      checks++;
      if ({if1.dout_valid, if1.din_ready, if1.busy, if1.dout_last} !== {!h, c == 13, 1'b1, c == 13}) begin
        errors++; $display("FAIL hold c=%0d: got valid/ready/busy/last=%b, expected %b", c, {if1.dout_valid, if1.din_ready, if1.busy, if1.dout_last}, {!h, c == 13, 1'b1, c == 13});
      end
    end
    tick(); if1.hold = 1'b0; #3;
    checks++;
    if ({if1.busy, q1.size() == 0} !== 2'b01) begin
      errors++; $display("FAIL hold_end: got busy/qempty=%b, expected 01", {if1.busy, q1.size() == 0});
    end
  endtask
  task automatic test_reset_mid();
    tick(); if1.din = 8'hFF; if1.din_valid = 1'b1; #3;
    push1(8'hFF, 5);
    for (int c = 1; c <= 5; c++) begin
      tick(); if1.din_valid = 1'b0; rst = c == 5; #3;
      checks++;
      if (if1.dout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre c=%0d: got valid=%b, expected 1", c, if1.dout_valid); end
    end
    tick(); rst = 1'b0; if1.din = 8'h00; if1.din_valid = 1'b1; #3;
    checks++;
    if ({if1.dout_valid, if1.busy, if1.din_ready} !== 3'b001) begin
      errors++; $display("FAIL rstmid_release: got valid/busy/ready=%b, expected 001", {if1.dout_valid, if1.busy, if1.din_ready});
    end
    push1(8'h00, 10);
    for (int c = 7; c <= 16; c++) begin
      tick(); if1.din_valid = 1'b0; #3;
      checks++;
      if ({if1.dout_valid, if1.dout, if1.dout_last} !== {1'b1, c == 7, c == 16}) begin
        errors++; $display("FAIL rstmid_frame c=%0d: got valid/dout/last=%b, expected %b", c, {if1.dout_valid, if1.dout, if1.dout_last}, {1'b1, c == 7, c == 16});
      end
    end
    tick(); #3;
    checks++;
    if ({if1.busy, q1.size() == 0} !== 2'b01) begin
      errors++; $display("FAIL rstmid_end: got busy/qempty=%b, expected 01", {if1.busy, q1.size() == 0});
    end
  endtask
  task automatic test_width4();
    tick(); if2.din = 4'hC; if2.din_valid = 1'b1; #3;
    push2(4'hC);
    for (int c = 1; c <= 10; c++) begin
      tick(); if2.din = 4'h5; if2.din_valid = c <= 5; #3;
      checks++;
      if ({if2.dout_valid, if2.din_ready, if2.dout_last} !== {1'b1, c == 5 || c == 10, c == 5 || c == 10}) begin
        errors++; $display("FAIL w4 c=%0d: got valid/ready/last=%b, expected %b", c, {if2.dout_valid, if2.din_ready, if2.dout_last}, {1'b1, c == 5 || c == 10, c == 5 || c == 10});
      end
      if (c == 5) push2(4'h5);
    end
    tick(); if2.din_valid = 1'b0; #3;
    checks++;
    if ({if2.busy, q2.size() == 0} !== 2'b01) begin
      errors++; $display("FAIL w4_end: got busy/qempty=%b, expected 01", {if2.busy, q2.size() == 0});
    end
  endtask
  task automatic test_random();
    int rem = 0;
    logic rdy;
    for (int c = 0; c < 320; c++) begin
      tick();
      if1.hold = c < 300 ? $urandom_range(3) == 0 : 1'b0;
      if1.din_valid = c < 300 ? 1'($urandom_range(1)) : 1'b0;
      if1.din = 8'($urandom);
      #3;
      rdy = !if1.hold && rem <= 1;
      checks++;
      if ({if1.din_ready, if1.dout_valid, if1.busy} !== {rdy, rem > 0 && !if1.hold, rem > 0}) begin
        errors++; $display("FAIL random c=%0d: got ready/valid/busy=%b, expected %b", c, {if1.din_ready, if1.dout_valid, if1.busy}, {rdy, rem > 0 && !if1.hold, rem > 0});
      end
      if (if1.din_valid && rdy) begin
        push1(if1.din, 10);
        rem = 10;
      end else if (!if1.hold && rem > 0) rem--;
    end
    checks++;
    if (q1.size() != 0) begin errors++; $display("FAIL random_drain: got %0d pending bits, expected 0", q1.size()); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_width4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
